// File: rtl/rq_mul_seq.sv
// Coefficient sequencer for a ternary-operand ring multiplier: latches r, clears the
// accumulator array, steps through N coefficients and waits out the multiplier latency.
// Optional abort input enabled by defining RQ_MUL_SEQ_ABORT_EN.
module rq_mul_seq #(
    parameter int N       = 701,
    parameter int R_W     = 2,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [N*R_W-1:0]      r_in,
`ifdef RQ_MUL_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  mul_clr,
    output logic                  mul_step,
    output logic [R_W-1:0]        mul_coef,
    output logic [$clog2(N)-1:0]  coef_idx,
    output logic                  busy,
    output logic                  done_valid,
    input  logic                  done_ready
);

    localparam int                IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
    localparam logic [2:0]        DRN_LAST = 3'((MUL_LAT > 0) ? (MUL_LAT - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx_q;
    logic [2:0]         drn_q;
    logic [N*R_W-1:0]   r_buf;
    logic               abort_i;

`ifdef RQ_MUL_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx_q <= '0;
            drn_q <= '0;
        end else begin
            state <= state_nxt;
            idx_q <= (state == S_RUN && state_nxt == S_RUN) ? idx_q + IDX_W'(1) : '0;
            drn_q <= (state == S_DRAIN && state_nxt == S_DRAIN) ? drn_q + 3'd1 : 3'd0;
        end
    end

    // Operand buffer shifts down so the current coefficient always sits in the low bits.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start_valid) begin
            r_buf <= r_in;
        end else if (state == S_RUN) begin
            r_buf <= r_buf >> R_W;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        mul_clr     = 1'b0;
        mul_step    = 1'b0;
        mul_coef    = '0;
        coef_idx    = '0;
        busy        = 1'b1;
        done_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                busy        = 1'b0;
                start_ready = 1'b1;
                if (start_valid) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                mul_clr   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                mul_step = 1'b1;
                mul_coef = r_buf[R_W-1:0];
                coef_idx = idx_q;
                if (idx_q == IDX_LAST) state_nxt = (MUL_LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (drn_q == DRN_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort only cancels work in flight; a finished product still waits for its consumer.
        if (abort_i && (state == S_CLEAR || state == S_RUN || state == S_DRAIN)) begin
            state_nxt = S_IDLE;
        end
    end

endmodule

// File: tb/tb_rq_mul_seq.sv
// Directed bench for rq_mul_seq: small N=5 instances (MUL_LAT 1 and 0) plus a full N=701
// instance feeding a behavioural accumulator array checked against a cyclic convolution.
module tb_rq_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vec = 0;
    int err = 0;

    // Instance a: N=5, MUL_LAT=1
    logic       a_sv = 1'b0, a_sr, a_clr, a_step, a_busy, a_dv, a_dr = 1'b1;
    logic [9:0] a_r = '0;
    logic [1:0] a_coef;
    logic [2:0] a_idx;
    // Instance b: N=5, MUL_LAT=0
    logic       b_sv = 1'b0, b_sr, b_clr, b_step, b_busy, b_dv, b_dr = 1'b1;
    logic [9:0] b_r = '0;
    logic [1:0] b_coef;
    logic [2:0] b_idx;
    // Instance c: N=701, MUL_LAT=1
    logic          c_sv = 1'b0, c_sr, c_clr, c_step, c_busy, c_dv, c_dr = 1'b1;
    logic [1401:0] c_r = '0;
    logic [1:0]    c_coef;
    logic [9:0]    c_idx;
`ifdef RQ_MUL_SEQ_ABORT_EN
    logic a_abort = 1'b0, b_abort = 1'b0, c_abort = 1'b0;
`endif

    rq_mul_seq #(.N(5), .R_W(2), .MUL_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start_valid(a_sv), .start_ready(a_sr), .r_in(a_r),
`ifdef RQ_MUL_SEQ_ABORT_EN
        .abort(a_abort),
`endif
        .mul_clr(a_clr), .mul_step(a_step), .mul_coef(a_coef), .coef_idx(a_idx),
        .busy(a_busy), .done_valid(a_dv), .done_ready(a_dr)
    );

    rq_mul_seq #(.N(5), .R_W(2), .MUL_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start_valid(b_sv), .start_ready(b_sr), .r_in(b_r),
`ifdef RQ_MUL_SEQ_ABORT_EN
        .abort(b_abort),
`endif
        .mul_clr(b_clr), .mul_step(b_step), .mul_coef(b_coef), .coef_idx(b_idx),
        .busy(b_busy), .done_valid(b_dv), .done_ready(b_dr)
    );

    rq_mul_seq #(.N(701), .R_W(2), .MUL_LAT(1)) dut_c (
        .clk(clk), .rst(rst), .start_valid(c_sv), .start_ready(c_sr), .r_in(c_r),
`ifdef RQ_MUL_SEQ_ABORT_EN
        .abort(c_abort),
`endif
        .mul_clr(c_clr), .mul_step(c_step), .mul_coef(c_coef), .coef_idx(c_idx),
        .busy(c_busy), .done_valid(c_dv), .done_ready(c_dr)
    );

    // {start_ready, mul_clr, mul_step, mul_coef[1:0], coef_idx[2:0], busy, done_valid}
    localparam logic [9:0] RST_PACK = 10'b10_0000_0000;

    logic [1:0]  s1 [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [1:0]  s5 [5] = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
    logic [1:0]  rc   [701];
    logic [12:0] av   [701];
    logic [12:0] acc  [701];
    logic [12:0] gold [701];

    function automatic logic [9:0] pack5(input logic [1:0] c [5]);
        logic [9:0] v;
        v = '0;
        for (int k = 0; k < 5; k++) v[k*2 +: 2] = c[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        rst = 1'b1;
        tick();
        tick();
        obs = {a_sr, a_clr, a_step, a_coef, a_idx, a_busy, a_dv};
        vec++;
        if (obs !== RST_PACK) begin
            err++;
            $display("FAIL reset_outputs: got %b want %b", obs, RST_PACK);
        end
        vec++;
        if ({b_busy, b_dv, c_busy, c_dv, b_sr, c_sr} !== 6'b000011) begin
            err++;
            $display("FAIL reset_other: got %b want 000011", {b_busy, b_dv, c_busy, c_dv, b_sr, c_sr});
        end
        rst = 1'b0;
        tick();
    endtask

    // One job on instance a with done_ready high; optionally scramble r_in after acceptance.
    task automatic test_job(input logic scramble);
        logic [1:0] cf [5];
        logic [9:0] obs, exp;
        logic       e_step, e_busy;
        logic [1:0] e_coef;
        logic [2:0] e_idx;
        if (scramble) cf = s5; else cf = s1;
        a_dr = 1'b1;
        a_r  = pack5(cf);
        a_sv = 1'b1;
        vec++;
        if (a_sr !== 1'b1) begin
            err++;
            $display("FAIL job_start_ready: got %b want 1", a_sr);
        end
        tick();
        a_sv = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            e_step = (k >= 2 && k <= 6);
            e_busy = (k >= 1 && k <= 8);
            e_coef = 2'd0;
            e_idx  = 3'd0;
            if (e_step) begin
                e_coef = cf[k-2];
                e_idx  = 3'(k - 2);
            end
            exp = {!e_busy, (k == 1), e_step, e_coef, e_idx, e_busy, (k == 8)};
            obs = {a_sr, a_clr, a_step, a_coef, a_idx, a_busy, a_dv};
            vec++;
            if (obs !== exp) begin
                err++;
                $display("FAIL job_cycle%0d scramble=%0d: got %b want %b", k, scramble, obs, exp);
            end
            if (scramble) a_r = 10'($urandom);
            tick();
        end
    endtask

    task automatic test_lat0();
        logic [9:0] obs, exp;
        logic       e_step, e_busy;
        logic [1:0] e_coef;
        logic [2:0] e_idx;
        b_dr = 1'b1;
        b_r  = pack5(s1);
        b_sv = 1'b1;
        tick();
        b_sv = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            e_step = (k >= 2 && k <= 6);
            e_busy = (k >= 1 && k <= 7);
            e_coef = 2'd0;
            e_idx  = 3'd0;
            if (e_step) begin
                e_coef = s1[k-2];
                e_idx  = 3'(k - 2);
            end
            exp = {!e_busy, (k == 1), e_step, e_coef, e_idx, e_busy, (k == 7)};
            obs = {b_sr, b_clr, b_step, b_coef, b_idx, b_busy, b_dv};
            vec++;
            if (obs !== exp) begin
                err++;
                $display("FAIL lat0_cycle%0d: got %b want %b", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_done_hold();
        int k;
        a_dr = 1'b0;
        a_r  = pack5(s1);
        a_sv = 1'b1;
        tick();
        a_sv = 1'b0;
        k = 1;
        while (a_dv !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        vec++;
        if (k !== 8) begin
            err++;
            $display("FAIL hold_done_latency: got cycle %0d want 8", k);
        end
        for (int h = 0; h < 10; h++) begin
            vec++;
            if ({a_dv, a_sr, a_busy} !== 3'b101) begin
                err++;
                $display("FAIL hold_cycle%0d {dv,sr,busy}: got %b want 101", h, {a_dv, a_sr, a_busy});
            end
            a_sv = (h == 3);
            tick();
        end
        a_sv = 1'b0;
        a_dr = 1'b1;
        tick();
        vec++;
        if ({a_dv, a_sr, a_busy} !== 3'b010) begin
            err++;
            $display("FAIL hold_release {dv,sr,busy}: got %b want 010", {a_dv, a_sr, a_busy});
        end
        for (int h = 0; h < 4; h++) begin
            vec++;
            if ({a_clr, a_busy} !== 2'b00) begin
                err++;
                $display("FAIL hold_ignored_start%0d {clr,busy}: got %b want 00", h, {a_clr, a_busy});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [9:0] obs;
        a_dr = 1'b1;
        a_r  = pack5(s1);
        a_sv = 1'b1;
        tick();
        a_sv = 1'b0;
        tick();
        tick();
        tick();
        vec++;
        if ({a_step, a_idx, a_coef} !== {1'b1, 3'd2, 2'd0}) begin
            err++;
            $display("FAIL midrun_position {step,idx,coef}: got %b want 101000", {a_step, a_idx, a_coef});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {a_sr, a_clr, a_step, a_coef, a_idx, a_busy, a_dv};
        vec++;
        if (obs !== RST_PACK) begin
            err++;
            $display("FAIL midrun_reset: got %b want %b", obs, RST_PACK);
        end
        for (int h = 0; h < 8; h++) begin
            vec++;
            if ({a_busy, a_dv, a_step} !== 3'b000) begin
                err++;
                $display("FAIL midrun_discard%0d {busy,dv,step}: got %b want 000", h, {a_busy, a_dv, a_step});
            end
            tick();
        end
    endtask

    task automatic test_full();
        int cycle, steps, first_done, cmis, pmis;
        for (int i = 0; i < 701; i++) begin
            rc[i] = 2'($urandom_range(0, 2));
            c_r[i*2 +: 2] = rc[i];
            av[i]   = 13'($urandom);
            acc[i]  = 13'($urandom);
            gold[i] = '0;
        end
        // Ternary coding: 1 -> +1, 2 -> -1, 0 -> 0
        for (int i = 0; i < 701; i++) begin
            for (int j = 0; j < 701; j++) begin
                if (rc[i] == 2'd1) gold[(i + j) % 701] = gold[(i + j) % 701] + av[j];
                else if (rc[i] == 2'd2) gold[(i + j) % 701] = gold[(i + j) % 701] - av[j];
            end
        end
        c_dr = 1'b1;
        c_sv = 1'b1;
        tick();
        c_sv = 1'b0;
        cycle = 1;
        steps = 0;
        first_done = -1;
        cmis = 0;
        while (cycle <= 800 && first_done < 0) begin
            if (c_clr === 1'b1) begin
                for (int j = 0; j < 701; j++) acc[j] = '0;
            end
            if (c_step === 1'b1) begin
                if (steps < 701) begin
                    if (c_coef !== rc[steps] || c_idx !== 10'(steps)) cmis++;
                    for (int j = 0; j < 701; j++) begin
                        if (c_coef == 2'd1) acc[(j + steps) % 701] = acc[(j + steps) % 701] + av[j];
                        else if (c_coef == 2'd2) acc[(j + steps) % 701] = acc[(j + steps) % 701] - av[j];
                    end
                end
                steps++;
            end
            if (c_dv === 1'b1) first_done = cycle;
            tick();
            cycle++;
        end
        vec++;
        if (steps !== 701) begin
            err++;
            $display("FAIL full_step_count: got %0d want 701", steps);
        end
        vec++;
        if (first_done !== 704) begin
            err++;
            $display("FAIL full_done_cycle: got %0d want 704", first_done);
        end
        vec++;
        if (cmis !== 0) begin
            err++;
            $display("FAIL full_coef_sequence: got %0d bad steps want 0", cmis);
        end
        pmis = 0;
        for (int j = 0; j < 701; j++) if (acc[j] !== gold[j]) pmis++;
        vec++;
        if (pmis !== 0) begin
            err++;
            $display("FAIL full_product: got %0d wrong coefficients want 0", pmis);
        end
    endtask

`ifdef RQ_MUL_SEQ_ABORT_EN
    task automatic test_abort();
        logic [9:0] obs;
        a_dr = 1'b1;
        a_r  = pack5(s1);
        a_sv = 1'b1;
        tick();
        a_sv = 1'b0;
        for (int k = 1; k < 7; k++) tick();
        vec++;
        if ({a_busy, a_step, a_dv} !== 3'b100) begin
            err++;
            $display("FAIL abort_in_drain_pos {busy,step,dv}: got %b want 100", {a_busy, a_step, a_dv});
        end
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        obs = {a_sr, a_clr, a_step, a_coef, a_idx, a_busy, a_dv};
        vec++;
        if (obs !== RST_PACK) begin
            err++;
            $display("FAIL abort_drain_idle: got %b want %b", obs, RST_PACK);
        end
        for (int h = 0; h < 5; h++) begin
            vec++;
            if (a_dv !== 1'b0) begin
                err++;
                $display("FAIL abort_drain_no_done%0d: got %b want 0", h, a_dv);
            end
            tick();
        end
        a_dr = 1'b0;
        a_sv = 1'b1;
        tick();
        a_sv = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        vec++;
        if ({a_dv, a_busy} !== 2'b11) begin
            err++;
            $display("FAIL abort_in_done_ignored {dv,busy}: got %b want 11", {a_dv, a_busy});
        end
        a_dr = 1'b1;
        tick();
        vec++;
        if ({a_sr, a_dv} !== 2'b10) begin
            err++;
            $display("FAIL abort_done_release {sr,dv}: got %b want 10", {a_sr, a_dv});
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_job(1'b0);
        test_job(1'b1);
        test_lat0();
        test_done_hold();
        test_reset_mid_run();
        test_job(1'b0);
        test_full();
`ifdef RQ_MUL_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
